master_write_burst: RTL and testbench

MASTER_WRITE_BURST -- requirements
Module: master_write_burst

---
 rtl/axi_master_pkg.sv | 30 +++
 rtl/wbeat_buf.sv | 25 ++
 rtl/master_write_burst.sv | 162 ++++++++++++++++
 tb/tb_master_write_burst.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_pkg.sv
// Shared AXI master definitions: channel widths, response/burst encodings and
// the write-burst master state encoding.
package axi_master_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned SIZE_W = 3;
   localparam int unsigned BURST_W = 2;
   localparam int unsigned RESP_W = 2;

   localparam logic [RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      XFER = 2'd2,
      RESP = 2'd3
   } mwb_state_e;

   // One buffered write beat
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } wbeat_t;

endpackage

// File: rtl/wbeat_buf.sv
// Beat buffer for the write-burst master: synchronous write, combinational
// read, no reset (contents are don't-care until loaded).
module wbeat_buf
   import axi_master_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  wbeat_t            wbeat,
   input  logic [ADDR_W-1:0] raddr,
   output wbeat_t            rbeat_c
);

   wbeat_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wbeat;
   end

   assign rbeat_c = mem[raddr];

endmodule

// File: rtl/master_write_burst.sv
// AXI write-burst master: buffers a CPU burst of up to MAX_BEATS beats, then
// replays it as one INCR burst on AW/W and waits for the matching B response.
module master_write_burst
   import axi_master_pkg::*;
#(
   parameter logic [ID_W-1:0]   ID_VAL    = 4'b0001,
   parameter int unsigned       MAX_BEATS = 4,
   parameter logic [SIZE_W-1:0] SIZE      = 3'd2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]    req_len,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [STRB_W-1:0]   wr_strb,
   output logic                busy,
   output logic                done,
   output logic                resp_err,
   output logic [ID_W-1:0]     AWID_M,
   output logic [ADDR_W-1:0]   AWADDR_M,
   output logic [LEN_W-1:0]    AWLEN_M,
   output logic [SIZE_W-1:0]   AWSIZE_M,
   output logic [BURST_W-1:0]  AWBURST_M,
   output logic                AWVALID_M,
   input  logic                AWREADY_M,
   output logic [DATA_W-1:0]   WDATA_M,
   output logic [STRB_W-1:0]   WSTRB_M,
   output logic                WLAST_M,
   output logic                WVALID_M,
   input  logic                WREADY_M,
   input  logic [ID_W-1:0]     BID_M,
   input  logic [RESP_W-1:0]   BRESP_M,
   input  logic                BVALID_M,
   output logic                BREADY_M
);

   localparam int unsigned      BUF_AW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS - 1);

   mwb_state_e          state, state_nxt;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    load_cnt;
   logic [LEN_W-1:0]    w_cnt;
   logic                aw_done, w_done;
   logic                accept, load_beat, load_last;
   logic                aw_hs, w_hs, w_last_hs, b_hit;
   logic [BUF_AW-1:0]   rd_addr;
   wbeat_t              in_beat, rd_beat, first_beat;

   assign accept    = (state == IDLE) && req_valid;
   assign load_beat = (state == LOAD) && wr_valid;
   assign load_last = load_beat && (load_cnt == len_q);
   assign aw_hs     = AWVALID_M && AWREADY_M;
   assign w_hs      = WVALID_M && WREADY_M;
   assign w_last_hs = w_hs && (w_cnt == len_q);
   assign b_hit     = (state == RESP) && BVALID_M && (BID_M == ID_VAL);

   assign in_beat    = '{data: wr_data, strb: wr_strb};
   // Beat 0 may be the one being written this very cycle (single-beat burst)
   assign first_beat = (load_cnt == '0) ? in_beat : rd_beat;
   assign rd_addr    = (state == LOAD) ? '0 : BUF_AW'(w_cnt + 4'd1);

   wbeat_buf #(
      .DEPTH  (MAX_BEATS),
      .ADDR_W (BUF_AW)
   ) u_buf (
      .clk     (clk),
      .we      (load_beat),
      .waddr   (BUF_AW'(load_cnt)),
      .wbeat   (in_beat),
      .raddr   (rd_addr),
      .rbeat_c (rd_beat)
   );

   assign req_ready = (state == IDLE);
   assign wr_ready  = (state == LOAD);
   assign BREADY_M  = (state == RESP);
   assign busy      = rst && ((state != IDLE) || req_valid);
   assign AWID_M    = ID_VAL;
   assign AWLEN_M   = len_q;
   assign AWSIZE_M  = SIZE;
   assign AWBURST_M = AXI_BURST_INCR;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = LOAD;
         LOAD: if (load_last) state_nxt = XFER;
         XFER: if ((aw_done || aw_hs) && (w_done || w_last_hs)) state_nxt = RESP;
         RESP: if (b_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst datapath and registered channel outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q    <= '0;
         len_q     <= '0;
         load_cnt  <= '0;
         w_cnt     <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         AWVALID_M <= 1'b0;
         AWADDR_M  <= '0;
         WVALID_M  <= 1'b0;
         WLAST_M   <= 1'b0;
         WDATA_M   <= '0;
         WSTRB_M   <= 4'hF;
         done      <= 1'b0;
         resp_err  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            addr_q   <= req_addr;
            len_q    <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
            load_cnt <= '0;
            w_cnt    <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
         end
         if (load_beat && !load_last) load_cnt <= load_cnt + 4'd1;
         if (load_last) begin
            AWVALID_M <= 1'b1;
            AWADDR_M  <= addr_q;
            WVALID_M  <= 1'b1;
            WDATA_M   <= first_beat.data;
            WSTRB_M   <= first_beat.strb;
            WLAST_M   <= (len_q == '0);
         end
         if (aw_hs) begin
            AWVALID_M <= 1'b0;
            aw_done   <= 1'b1;
         end
         if (w_last_hs) begin
            WVALID_M <= 1'b0;
            WLAST_M  <= 1'b0;
            w_done   <= 1'b1;
         end else if (w_hs) begin
            w_cnt   <= w_cnt + 4'd1;
            WDATA_M <= rd_beat.data;
            WSTRB_M <= rd_beat.strb;
            WLAST_M <= ((w_cnt + 4'd1) == len_q);
         end
         if (b_hit) begin
            done     <= 1'b1;
            resp_err <= (BRESP_M != AXI_RESP_OKAY);
         end
      end
   end

endmodule

// File: tb/tb_master_write_burst.sv
// Directed self-checking bench for master_write_burst with default parameters.
module tb_master_write_burst;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_len = '0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        busy, done, resp_err;
   logic [3:0]  AWID_M, AWLEN_M;
   logic [31:0] AWADDR_M;
   logic [2:0]  AWSIZE_M;
   logic [1:0]  AWBURST_M;
   logic        AWVALID_M, AWREADY_M = 1'b1;
   logic [31:0] WDATA_M;
   logic [3:0]  WSTRB_M;
   logic        WLAST_M, WVALID_M, WREADY_M = 1'b1;
   logic [3:0]  BID_M = '0;
   logic [1:0]  BRESP_M = '0;
   logic        BVALID_M = 1'b0, BREADY_M;

   master_write_burst dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
      .busy(busy), .done(done), .resp_err(resp_err),
      .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
      .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
      .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
      .WREADY_M(WREADY_M),
      .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic w_stall = 1'b0;

   logic [31:0] exp_data [16];
   logic [3:0]  exp_strb [16];

   // Bus monitor, sampled at negedge; a valid&ready seen here completes at the next posedge
   int          aw_n, w_n, wlast_n, done_n;
   logic [3:0]  aw_len_seen;
   logic [31:0] aw_addr_first;
   logic        aw_seen, addr_changed, err_seen;
   logic [31:0] got_data [16];
   logic [3:0]  got_strb [16];
   logic        got_last [16];

   always @(negedge clk) begin
      if (AWVALID_M) begin
         if (!aw_seen) aw_addr_first = AWADDR_M;
         else if (AWADDR_M != aw_addr_first) addr_changed = 1'b1;
         aw_seen = 1'b1;
      end
      if (AWVALID_M && AWREADY_M) begin
         aw_n++;
         aw_len_seen = AWLEN_M;
      end
      if (WVALID_M && WREADY_M && w_n < 16) begin
         got_data[w_n] = WDATA_M;
         got_strb[w_n] = WSTRB_M;
         got_last[w_n] = WLAST_M;
         if (WLAST_M) wlast_n++;
         w_n++;
      end
      if (done) begin
         done_n++;
         err_seen = resp_err;
      end
   end

   // W-channel slave: ready tied high or toggling every cycle
   always @(posedge clk) begin
      #1;
      if (w_stall) WREADY_M = ~WREADY_M;
      else         WREADY_M = 1'b1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      aw_n = 0; w_n = 0; wlast_n = 0; done_n = 0;
      aw_seen = 1'b0; addr_changed = 1'b0; err_seen = 1'b0; aw_len_seen = '0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_req(input logic [31:0] a, input logic [3:0] l);
      req_addr  = a;
      req_len   = l;
      req_valid = 1'b1;
      #1;
      check_val("busy_on_req", 64'(busy), 64'd1);
      tick(1);
      req_valid = 1'b0;
   endtask

   task automatic load_beats(input int n);
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = exp_data[i];
         wr_strb  = exp_strb[i];
         tick(1);
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int t = 0;
      while (!BREADY_M && t < 100) begin
         tick(1);
         t++;
      end
      check_val(tag, 64'(BREADY_M), 64'd1);
   endtask

   task automatic wait_w(input string tag, input int n);
      int t = 0;
      while (w_n < n && t < 100) begin
         tick(1);
         t++;
      end
      check_val(tag, 64'(w_n), 64'(n));
   endtask

   task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
      BVALID_M = 1'b1;
      BID_M    = id;
      BRESP_M  = resp;
      tick(1);
      BVALID_M = 1'b0;
   endtask

   task automatic check_beats(input string tag, input int n);
      check_val({tag, "_wcount"}, 64'(w_n), 64'(n));
      check_val({tag, "_wlast_count"}, 64'(wlast_n), 64'd1);
      for (int i = 0; i < n && i < 16; i++) begin
         check_val($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
         check_val($sformatf("%s_strb%0d", tag, i), 64'(got_strb[i]), 64'(exp_strb[i]));
         check_val($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
      end
   endtask

   initial begin
      clear_mon();
      // Reset values
      #12;
      check_val("rst_req_ready", 64'(req_ready), 64'd1);
      check_val("rst_busy",      64'(busy), 64'd0);
      check_val("rst_wr_ready",  64'(wr_ready), 64'd0);
      check_val("rst_awvalid",   64'(AWVALID_M), 64'd0);
      check_val("rst_wvalid",    64'(WVALID_M), 64'd0);
      check_val("rst_wlast",     64'(WLAST_M), 64'd0);
      check_val("rst_bready",    64'(BREADY_M), 64'd0);
      check_val("rst_done",      64'(done), 64'd0);
      check_val("rst_resp_err",  64'(resp_err), 64'd0);
      check_val("rst_awaddr",    64'(AWADDR_M), 64'd0);
      check_val("rst_wdata",     64'(WDATA_M), 64'd0);
      check_val("rst_wstrb",     64'(WSTRB_M), 64'hF);
      check_val("rst_awid",      64'(AWID_M), 64'h1);
      check_val("awburst",       64'(AWBURST_M), 64'h1);
      check_val("awsize",        64'(AWSIZE_M), 64'h2);
      @(posedge clk); #1;
      rst = 1'b1;
      tick(2);

      // Single beat, all ready
      clear_mon();
      exp_data[0] = 32'hDEADBEEF; exp_strb[0] = 4'hF;
      send_req(32'h100, 4'd0);
      load_beats(1);
      check_val("t1_awvalid_on_entry", 64'(AWVALID_M), 64'd1);
      check_val("t1_wvalid_on_entry",  64'(WVALID_M), 64'd1);
      wait_resp("t1_reach_resp");
      send_b(4'h1, 2'b00);
      tick(3);
      check_val("t1_aw_count", 64'(aw_n), 64'd1);
      check_val("t1_awlen",    64'(aw_len_seen), 64'd0);
      check_val("t1_awaddr",   64'(aw_addr_first), 64'h100);
      check_beats("t1", 1);
      check_val("t1_done_count", 64'(done_n), 64'd1);
      check_val("t1_resp_err",   64'(err_seen), 64'd0);
      check_val("t1_idle_ready", 64'(req_ready), 64'd1);
      check_val("t1_idle_busy",  64'(busy), 64'd0);

      // Four beats with WREADY toggling
      clear_mon();
      for (int i = 0; i < 4; i++) begin
         exp_data[i] = 32'(i + 1);
         exp_strb[i] = 4'(4'h1 << i) | 4'h1;
      end
      w_stall = 1'b1;
      send_req(32'h200, 4'd3);
      req_valid = 1'b1;
      #1;
      check_val("t2_load_req_ready", 64'(req_ready), 64'd0);
      check_val("t2_load_wr_ready",  64'(wr_ready), 64'd1);
      req_valid = 1'b0;
      load_beats(4);
      wait_resp("t2_reach_resp");
      send_b(4'h1, 2'b00);
      tick(3);
      w_stall = 1'b0;
      check_val("t2_aw_count",   64'(aw_n), 64'd1);
      check_val("t2_awlen",      64'(aw_len_seen), 64'd3);
      check_val("t2_addr_stable", 64'(addr_changed), 64'd0);
      check_val("t2_awaddr_hold", 64'(AWADDR_M), 64'h200);
      check_beats("t2", 4);
      check_val("t2_done_count", 64'(done_n), 64'd1);

      // AWREADY held off until 5 cycles after all W beats
      clear_mon();
      exp_data[0] = 32'hA5A5_0001; exp_strb[0] = 4'hC;
      exp_data[1] = 32'hA5A5_0002; exp_strb[1] = 4'h3;
      AWREADY_M = 1'b0;
      send_req(32'h300, 4'd1);
      load_beats(2);
      wait_w("t3_w_done", 2);
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("t3_hold_bready%0d", i), 64'(BREADY_M), 64'd0);
         check_val($sformatf("t3_hold_awvalid%0d", i), 64'(AWVALID_M), 64'd1);
         check_val($sformatf("t3_hold_wvalid%0d", i), 64'(WVALID_M), 64'd0);
         tick(1);
      end
      AWREADY_M = 1'b1;
      wait_resp("t3_reach_resp");
      tick(2);
      check_val("t3_aw_count", 64'(aw_n), 64'd1);
      check_beats("t3", 2);

      // Mismatched BID ignored, then SLVERR
      send_b(4'h3, 2'b00);
      check_val("t4_bad_bid_stay", 64'(BREADY_M), 64'd1);
      check_val("t4_bad_bid_done", 64'(done_n), 64'd0);
      send_b(4'h1, 2'b10);
      tick(2);
      check_val("t4_done_count", 64'(done_n), 64'd1);
      check_val("t4_resp_err",   64'(err_seen), 64'd1);
      check_val("t4_idle",       64'(req_ready), 64'd1);

      // req_len beyond MAX_BEATS clamps to 4 beats
      clear_mon();
      for (int i = 0; i < 4; i++) begin
         exp_data[i] = 32'h7000_0000 + 32'(i);
         exp_strb[i] = 4'hF;
      end
      send_req(32'h400, 4'd7);
      load_beats(4);
      check_val("t5_wr_ready_off", 64'(wr_ready), 64'd0);
      check_val("t5_awlen_port",   64'(AWLEN_M), 64'd3);
      wait_resp("t5_reach_resp");
      send_b(4'h1, 2'b00);
      tick(2);
      check_val("t5_awlen", 64'(aw_len_seen), 64'd3);
      check_beats("t5", 4);
      check_val("t5_done_count", 64'(done_n), 64'd1);

      // Reset during XFER after two beats
      clear_mon();
      for (int i = 0; i < 4; i++) begin
         exp_data[i] = 32'hB000_0000 + 32'(i);
         exp_strb[i] = 4'hF;
      end
      AWREADY_M = 1'b0;
      send_req(32'h500, 4'd3);
      load_beats(4);
      wait_w("t6_two_beats", 2);
      rst = 1'b0;
      #1;
      check_val("t6_rst_awvalid",   64'(AWVALID_M), 64'd0);
      check_val("t6_rst_wvalid",    64'(WVALID_M), 64'd0);
      check_val("t6_rst_bready",    64'(BREADY_M), 64'd0);
      check_val("t6_rst_req_ready", 64'(req_ready), 64'd1);
      check_val("t6_rst_wstrb",     64'(WSTRB_M), 64'hF);
      tick(1);
      rst = 1'b1;
      AWREADY_M = 1'b1;
      tick(3);
      check_val("t6_no_done", 64'(done_n), 64'd0);
      check_val("t6_w_count", 64'(w_n), 64'd2);

      clear_mon();
      exp_data[0] = 32'h1234_5678; exp_strb[0] = 4'h5;
      send_req(32'h600, 4'd0);
      load_beats(1);
      wait_resp("t6_post_resp");
      send_b(4'h1, 2'b00);
      tick(2);
      check_val("t6_post_aw", 64'(aw_n), 64'd1);
      check_val("t6_post_awaddr", 64'(aw_addr_first), 64'h600);
      check_beats("t6_post", 1);
      check_val("t6_post_done", 64'(done_n), 64'd1);
      check_val("t6_post_err",  64'(err_seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
